// File: rtl/fifo_rr_arb_ctrl_pkg.sv
// Shared definitions for the packet-aware round-robin FIFO drain arbiter:
// FSM state encoding and a constant ceil(log2) helper for port widths.
package fifo_rr_arb_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } arb_state_e;

    // ceil(log2(value)), never less than 1 so a 1-bit index always exists.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 32'sd0;
        v      = value - 32'sd1;
        while (v > 32'sd0) begin
            result = result + 32'sd1;
            v      = v / 32'sd2;
        end
        return (result < 32'sd1) ? 32'sd1 : result;
    endfunction

endpackage

// File: rtl/fifo_rr_arb_ctrl_rr_pick.sv
// Rotate-priority encoder: returns the first requesting index after ptr,
// wrapping modulo N_SRC, so the most recently served source goes last.
module rr_pick
    import fifo_rr_arb_ctrl_pkg::*;
#(
    parameter  int N_SRC = 4,
    localparam int ID_W  = clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  idx,
    output logic             valid
);

    logic [ID_W-1:0] cand_s;

    // Walk candidates from farthest to nearest so the nearest requester after ptr wins.
    always_comb begin
        idx    = {ID_W{1'b0}};
        cand_s = {ID_W{1'b0}};
        for (int k = N_SRC; k >= 32'sd1; k--) begin
            cand_s = ID_W'((int'(ptr) + k) % N_SRC);
            idx    = req[cand_s] ? cand_s : idx;
        end
    end

    assign valid = |req;

endmodule

// File: rtl/fifo_rr_arb_ctrl.sv
// Packet-aware round-robin arbiter draining N_SRC FWFT source FIFOs into one
// downstream FIFO. A grant is held for a whole packet (or until the word cap
// forces a cut), then the pointer rotates past the served source.
module fifo_rr_arb_ctrl
    import fifo_rr_arb_ctrl_pkg::*;
#(
    parameter  int N_SRC         = 4,
    parameter  int D_WIDTH       = 64,
    parameter  int MAX_PKT_WORDS = 256,
    parameter  int CNT_WIDTH     = 16,
    localparam int ID_W          = clog2(N_SRC)
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic [N_SRC*D_WIDTH-1:0]   src_dout,
    input  logic [N_SRC-1:0]           src_last,
    input  logic [N_SRC-1:0]           src_empty,
    output logic [N_SRC-1:0]           src_rd_en,
    output logic [D_WIDTH-1:0]         dst_din,
    output logic                       dst_last,
    output logic                       dst_wr_en,
    input  logic                       dst_full,
    output logic [ID_W-1:0]            grant_id,
    output logic                       busy,
    output logic                       err_overrun,
    output logic [CNT_WIDTH-1:0]       pkt_cnt
);

    localparam int              WC_W     = clog2(MAX_PKT_WORDS);
    localparam logic [WC_W-1:0] WC_LIMIT = WC_W'(MAX_PKT_WORDS - 32'sd1);

    arb_state_e           state_r;
    arb_state_e           state_nx_s;
    logic [ID_W-1:0]      grant_r;
    logic [ID_W-1:0]      rr_ptr_r;
    logic [WC_W-1:0]      word_cnt_r;
    logic [CNT_WIDTH-1:0] pkt_cnt_r;
    logic                 err_r;

    logic [ID_W-1:0]      pick_idx_s;
    logic                 pick_valid_s;
    logic                 cap_s;
    logic                 xfer_s;
    logic                 eop_s;
    logic                 cut_s;

    rr_pick #(
        .N_SRC (N_SRC)
    ) u_rr_pick (
        .req   (~src_empty),
        .ptr   (rr_ptr_r),
        .idx   (pick_idx_s),
        .valid (pick_valid_s)
    );

    assign cap_s = (word_cnt_r == WC_LIMIT);

    // Zero-latency transfer path; every strobe is gated by XFER so reset silences it at once.
    always_comb begin
        src_rd_en = {N_SRC{1'b0}};
        dst_din   = src_dout[int'(grant_r)*D_WIDTH +: D_WIDTH];
        dst_last  = 1'b0;
        xfer_s    = 1'b0;
        if (state_r == ST_XFER) begin
            xfer_s   = ~src_empty[grant_r] & ~dst_full;
            dst_last = src_last[grant_r] | cap_s;
        end else begin
            xfer_s   = 1'b0;
            dst_last = 1'b0;
        end
        dst_wr_en          = xfer_s;
        src_rd_en[grant_r] = xfer_s;
        eop_s              = xfer_s & dst_last;
        cut_s              = eop_s & ~src_last[grant_r];
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next state: leave IDLE on any request, return after the packet's final word.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    state_nx_s = ST_XFER;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (eop_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_XFER;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Grant capture, rotation pointer, per-packet word count and completed-packet count.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            grant_r    <= {ID_W{1'b0}};
            rr_ptr_r   <= ID_W'(N_SRC - 32'sd1);
            word_cnt_r <= {WC_W{1'b0}};
            pkt_cnt_r  <= {CNT_WIDTH{1'b0}};
        end else if (state_r == ST_IDLE) begin
            if (pick_valid_s) begin
                grant_r    <= pick_idx_s;
                word_cnt_r <= {WC_W{1'b0}};
            end
        end else if (eop_s) begin
            word_cnt_r <= {WC_W{1'b0}};
            rr_ptr_r   <= grant_r;
            pkt_cnt_r  <= pkt_cnt_r + CNT_WIDTH'(1'b1);
        end else if (xfer_s) begin
            word_cnt_r <= word_cnt_r + WC_W'(1'b1);
        end
    end

    // Overrun flag: set when the word cap cuts a packet, held until reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            err_r <= 1'b0;
        end else if (cut_s) begin
            err_r <= 1'b1;
        end
    end

    assign grant_id    = grant_r;
    assign busy        = (state_r == ST_XFER);
    assign err_overrun = err_r;
    assign pkt_cnt     = pkt_cnt_r;

endmodule

// File: tb/tb_fifo_rr_arb_ctrl.sv
// Bench for fifo_rr_arb_ctrl: per-source queue models feed the DUT, a
// scoreboard of expected downstream words is checked on every write, a vector
// table covers the combinational transfer path, and hand sequences cover the
// multi-cycle corner cases.
module tb_fifo_rr_arb_ctrl;

    localparam int NS   = 4;
    localparam int DW   = 16;
    localparam int MAXW = 4;
    localparam int CW   = 8;

    logic             CLK;
    logic             RST_N;
    logic [NS*DW-1:0] src_dout;
    logic [NS-1:0]    src_last;
    logic [NS-1:0]    src_empty;
    logic [NS-1:0]    src_rd_en;
    logic [DW-1:0]    dst_din;
    logic             dst_last;
    logic             dst_wr_en;
    logic             dst_full;
    logic [1:0]       grant_id;
    logic             busy;
    logic             err_overrun;
    logic [CW-1:0]    pkt_cnt;

    typedef struct packed { logic last; logic [DW-1:0] data; } word_t;
    typedef struct packed { logic [1:0] src; logic last; logic [DW-1:0] data; } exp_t;
    typedef struct packed {
        logic [3:0] empty; logic full; logic [3:0] last;
        logic [3:0] rd;    logic wr;   logic dl;
    } vec_t;

    word_t srcq [NS][$];
    exp_t  exp_q [$];
    vec_t  tv [7];
    int    total, bad, cyc, wr_count, last_wr_cyc, n0;
    bit    have_prev, prev_last, gap_chk;

    fifo_rr_arb_ctrl #(
        .N_SRC         (NS),
        .D_WIDTH       (DW),
        .MAX_PKT_WORDS (MAXW),
        .CNT_WIDTH     (CW)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .src_dout    (src_dout),
        .src_last    (src_last),
        .src_empty   (src_empty),
        .src_rd_en   (src_rd_en),
        .dst_din     (dst_din),
        .dst_last    (dst_last),
        .dst_wr_en   (dst_wr_en),
        .dst_full    (dst_full),
        .grant_id    (grant_id),
        .busy        (busy),
        .err_overrun (err_overrun),
        .pkt_cnt     (pkt_cnt)
    );

    initial begin
        CLK = 1'b0;
        forever #10 CLK = ~CLK;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    function automatic logic [DW-1:0] mkw(input int s, input int tag, input int w);
        return DW'((s << 12) | (tag << 8) | w);
    endfunction

    task automatic add_word(input int s, input int tag, input int w, input logic last);
        word_t wd;
        wd.last = last;
        wd.data = mkw(s, tag, w);
        srcq[s].push_back(wd);
    endtask

    task automatic add_pkt(input int s, input int tag, input int n);
        for (int w = 0; w < n; w++) add_word(s, tag, w, (w == n - 1));
    endtask

    task automatic push_exp(input int s, input int tag, input int w, input logic last);
        exp_t e;
        e.src  = 2'(s);
        e.last = last;
        e.data = mkw(s, tag, w);
        exp_q.push_back(e);
    endtask

    task automatic exp_pkt(input int s, input int tag, input int n);
        for (int w = 0; w < n; w++) push_exp(s, tag, w, (w == n - 1));
    endtask

    task automatic drive_heads();
        for (int i = 0; i < NS; i++) begin
            if (srcq[i].size() > 0) begin
                src_empty[i]           = 1'b0;
                src_dout[i*DW +: DW]   = srcq[i][0].data;
                src_last[i]            = srcq[i][0].last;
            end else begin
                src_empty[i]           = 1'b1;
                src_dout[i*DW +: DW]   = {DW{1'b0}};
                src_last[i]            = 1'b0;
            end
        end
    endtask

    // One clock: sample mid-cycle, score any write, then advance and pop read sources.
    task automatic cycle();
        exp_t          e;
        logic [NS-1:0] rd;
        #1;
        check("rd_on_empty", 32'(src_rd_en & src_empty), 32'd0);
        check("wr_while_full", 32'(dst_wr_en & dst_full), 32'd0);
        if (dst_wr_en) begin
            if (exp_q.size() == 0) begin
                check("unexpected_wr", 32'(dst_din), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("dst_din", 32'(dst_din), 32'(e.data));
                check("dst_last", 32'(dst_last), 32'(e.last));
                check("wr_grant", 32'(grant_id), 32'(e.src));
                check("wr_rd_en", 32'(src_rd_en), 32'(4'b0001 << e.src));
            end
            if (gap_chk && have_prev) begin
                if (prev_last) check("gap_cycles", 32'(cyc - last_wr_cyc), 32'd2);
                else           check("burst_cycles", 32'(cyc - last_wr_cyc), 32'd1);
            end
            have_prev   = 1'b1;
            prev_last   = dst_last;
            last_wr_cyc = cyc;
            wr_count++;
        end
        rd = src_rd_en;
        @(posedge CLK);
        cyc++;
        #1;
        for (int i = 0; i < NS; i++) begin
            if (rd[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
        end
        drive_heads();
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < max_cyc) begin
            cycle();
            n++;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
        check("drain_idle", 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        exp_q.delete();
        for (int i = 0; i < NS; i++) srcq[i].delete();
        drive_heads();
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
    endtask

    initial begin
        // Grant held on source 1 mid-packet: {empty, full, last} -> {rd_en, wr_en, dst_last}
        tv[0] = '{4'b0000, 1'b0, 4'b0000, 4'b0010, 1'b1, 1'b0};
        tv[1] = '{4'b0010, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0};
        tv[2] = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0};
        tv[3] = '{4'b0010, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0};
        tv[4] = '{4'b0000, 1'b0, 4'b0010, 4'b0010, 1'b1, 1'b1};
        tv[5] = '{4'b1101, 1'b0, 4'b1101, 4'b0010, 1'b1, 1'b0};
        tv[6] = '{4'b0010, 1'b0, 4'b0010, 4'b0000, 1'b0, 1'b1};

        total = 0; bad = 0; cyc = 0; wr_count = 0; last_wr_cyc = 0;
        have_prev = 1'b0; prev_last = 1'b0; gap_chk = 1'b0;
        dst_full = 1'b0;
        src_dout = {NS*DW{1'b0}};
        do_reset();

        check("rst_grant", 32'(grant_id), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err_overrun), 32'd0);
        check("rst_pkt", 32'(pkt_cnt), 32'd0);
        check("rst_rd_en", 32'(src_rd_en), 32'd0);
        check("rst_wr_en", 32'(dst_wr_en), 32'd0);

        // 3-word packet on src0: one arbitration cycle, then three back-to-back writes
        add_pkt(0, 1, 3); exp_pkt(0, 1, 3); drive_heads();
        cycle();
        check("t1_grant", 32'(grant_id), 32'd0);
        check("t1_busy", 32'(busy), 32'd1);
        n0 = wr_count;
        repeat (3) cycle();
        check("t1_writes", 32'(wr_count - n0), 32'd3);
        check("t1_busy_drop", 32'(busy), 32'd0);
        check("t1_pkt", 32'(pkt_cnt), 32'd1);

        // Combinational transfer path under forced input patterns, grant on src1
        add_pkt(1, 2, 2); exp_pkt(1, 2, 2); drive_heads();
        cycle();
        check("tv_grant", 32'(grant_id), 32'd1);
        for (int i = 0; i < 7; i++) begin
            src_empty = tv[i].empty;
            dst_full  = tv[i].full;
            src_last  = tv[i].last;
            src_dout  = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
            #1;
            check("tv_rd_en", 32'(src_rd_en), 32'(tv[i].rd));
            check("tv_wr_en", 32'(dst_wr_en), 32'(tv[i].wr));
            check("tv_dst_last", 32'(dst_last), 32'(tv[i].dl));
            check("tv_dst_din", 32'(dst_din), 32'h0000_A001);
        end
        dst_full = 1'b0;
        drive_heads();
        drain(20);
        check("tv_pkt", 32'(pkt_cnt), 32'd2);

        // All sources backlogged: order 0,1,2,3,0 with one gap cycle between packets
        do_reset();
        for (int s = 0; s < NS; s++) add_pkt(s, 3, 2);
        add_pkt(0, 4, 2);
        for (int s = 0; s < NS; s++) exp_pkt(s, 3, 2);
        exp_pkt(0, 4, 2);
        drive_heads();
        gap_chk = 1'b1; have_prev = 1'b0;
        drain(60);
        gap_chk = 1'b0;
        check("t2_pkt", 32'(pkt_cnt), 32'd5);

        // dst_full toggling every other cycle mid-packet on src2
        add_pkt(2, 5, 3); exp_pkt(2, 5, 3); drive_heads();
        n0 = wr_count;
        for (int k = 0; k < 40 && (exp_q.size() != 0 || busy); k++) begin
            dst_full = (k % 2 == 1);
            cycle();
            if (busy) check("t3_grant_held", 32'(grant_id), 32'd2);
        end
        dst_full = 1'b0;
        check("t3_writes", 32'(wr_count - n0), 32'd3);
        check("t3_exp_left", 32'(exp_q.size()), 32'd0);
        check("t3_src_left", 32'(srcq[2].size()), 32'd0);
        check("t3_pkt", 32'(pkt_cnt), 32'd6);

        // src1 empties mid-packet for 5 cycles while src2 waits
        add_word(1, 6, 0, 1'b0);
        add_pkt(2, 7, 2);
        push_exp(1, 6, 0, 1'b0); push_exp(1, 6, 1, 1'b0); push_exp(1, 6, 2, 1'b1);
        exp_pkt(2, 7, 2);
        drive_heads();
        cycle();
        check("t4_grant", 32'(grant_id), 32'd1);
        cycle();
        n0 = wr_count;
        repeat (5) begin
            cycle();
            check("t4_grant_held", 32'(grant_id), 32'd1);
            check("t4_busy", 32'(busy), 32'd1);
        end
        check("t4_no_writes", 32'(wr_count - n0), 32'd0);
        add_word(1, 6, 1, 1'b0); add_word(1, 6, 2, 1'b1);
        drive_heads();
        drain(30);
        check("t4_pkt", 32'(pkt_cnt), 32'd8);

        // Exactly MAX_PKT_WORDS words ending naturally, then a 6-word packet cut at 4
        add_pkt(0, 8, 4); exp_pkt(0, 8, 4); drive_heads();
        drain(30);
        check("t5_err_exact", 32'(err_overrun), 32'd0);
        check("t5_pkt_exact", 32'(pkt_cnt), 32'd9);
        add_pkt(0, 9, 6);
        push_exp(0, 9, 0, 1'b0); push_exp(0, 9, 1, 1'b0); push_exp(0, 9, 2, 1'b0);
        push_exp(0, 9, 3, 1'b1); push_exp(0, 9, 4, 1'b0); push_exp(0, 9, 5, 1'b1);
        drive_heads();
        drain(40);
        check("t5_err_cut", 32'(err_overrun), 32'd1);
        check("t5_pkt_cut", 32'(pkt_cnt), 32'd11);

        // Reset mid-packet on src3, then arbitration restarts at source 0
        add_pkt(3, 10, 2); push_exp(3, 10, 0, 1'b0); drive_heads();
        cycle();
        check("t6_grant", 32'(grant_id), 32'd3);
        cycle();
        #1;
        check("t6_pre_wr", 32'(dst_wr_en), 32'd1);
        check("t6_pre_last", 32'(dst_last), 32'd1);
        RST_N = 1'b0;
        #1;
        check("t6_rst_rd_en", 32'(src_rd_en), 32'd0);
        check("t6_rst_wr_en", 32'(dst_wr_en), 32'd0);
        check("t6_rst_last", 32'(dst_last), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_grant", 32'(grant_id), 32'd0);
        check("t6_rst_pkt", 32'(pkt_cnt), 32'd0);
        check("t6_rst_err", 32'(err_overrun), 32'd0);
        exp_q.delete();
        @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        check("t6_rel_busy", 32'(busy), 32'd0);
        add_pkt(0, 11, 2); exp_pkt(0, 11, 2); push_exp(3, 10, 1, 1'b1);
        drive_heads();
        drain(30);
        check("t6_pkt", 32'(pkt_cnt), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
